// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, frame counter, and pad-registered
// active-low syncs plus colour that is blanked outside the visible window.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic [1:0] R_in,
    input  logic [1:0] G_in,
    input  logic [1:0] B_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_active,
    output logic [9:0] counter,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [1:0] R,
    output logic [1:0] G,
    output logic [1:0] B
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic [9:0] r_counter;
    logic       r_hsync;
    logic       r_vsync;
    logic [1:0] r_r;
    logic [1:0] r_g;
    logic [1:0] r_b;

    logic w_h_last;
    logic w_v_last;
    logic w_video_active;
    logic w_hsync_n;
    logic w_vsync_n;

    // Decode the current raster position into wrap, visibility and sync terms
    always_comb begin
        w_h_last       = (r_h_cnt == H_LAST);
        w_v_last       = (r_v_cnt == V_LAST);
        w_video_active = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
        w_hsync_n      = !((r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_END));
        w_vsync_n      = !((r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_END));
    end

    // Raster counters; the frame counter steps on the same edge as the (0,0) wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt   <= 10'd0;
            r_v_cnt   <= 10'd0;
            r_counter <= 10'd0;
        end else if (clk_en) begin
            if (w_h_last) begin
                r_h_cnt <= 10'd0;
                if (w_v_last) begin
                    r_v_cnt   <= 10'd0;
                    r_counter <= r_counter + 10'd1;
                end else begin
                    r_v_cnt <= r_v_cnt + 10'd1;
                end
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // Pad registers: syncs and colour share one edge so they stay mutually aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_r     <= 2'b00;
            r_g     <= 2'b00;
            r_b     <= 2'b00;
        end else if (clk_en) begin
            r_hsync <= w_hsync_n;
            r_vsync <= w_vsync_n;
            r_r     <= w_video_active ? R_in : 2'b00;
            r_g     <= w_video_active ? G_in : 2'b00;
            r_b     <= w_video_active ? B_in : 2'b00;
        end
    end

    assign pix_x        = r_h_cnt;
    assign pix_y        = r_v_cnt;
    assign video_active = w_video_active;
    assign frame_start  = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
    assign counter      = r_counter;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign R            = r_r;
    assign G            = r_g;
    assign B            = r_b;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines

REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, pixel clock
- rst_n, in, 1, asynchronous active-low reset
- clk_en, in, 1, pixel advance enable
- R_in, in, 2, red from the background/sprite logic for the current pix_x/pix_y
- G_in, in, 2, green, same timing as R_in
- B_in, in, 2, blue, same timing as R_in
- pix_x, out, 10, current horizontal count
- pix_y, out, 10, current vertical count
- video_active, out, 1, current position is visible
- counter, out, 10, frame counter for animation
- frame_start, out, 1, counters at (0,0)
- hsync, out, 1, active-low horizontal sync, registered
- vsync, out, 1, active-low vertical sync, registered
- R, out, 2, registered red to the pads
- G, out, 2, registered green to the pads
- B, out, 2, registered blue to the pads

Function
REQ-003 SHALL define H_TOTAL = sum of the H parameters (800) and V_TOTAL = sum of the V parameters (525).
REQ-004 SHALL keep h_cnt in 0..H_TOTAL-1; when clk_en=1, h_cnt increments each clk and wraps from H_TOTAL-1 to 0.
REQ-005 SHALL increment v_cnt only on an h_cnt wrap, wrapping from V_TOTAL-1 to 0; v_cnt SHALL stay in 0..V_TOTAL-1.
REQ-006 SHALL hold all counters and all registered outputs while clk_en=0.
REQ-007 SHALL drive pix_x=h_cnt and pix_y=v_cnt directly from the counter registers.
REQ-008 SHALL drive video_active=1 iff h_cnt<H_VISIBLE and v_cnt<V_VISIBLE, combinationally.
REQ-009 SHALL drive frame_start=1 iff h_cnt=0 and v_cnt=0, combinationally.
REQ-010 SHALL increment counter (10-bit, modulo 1024) when clk_en=1, h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, so it changes together with the (0,0) wrap.
REQ-011 SHALL register hsync=0 iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751), else 1.
REQ-012 SHALL register vsync=0 iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491), else 1.
REQ-013 SHALL register R/G/B = R_in/G_in/B_in when video_active=1, else 2'b00.
REQ-014 SHALL sample R/G/B, hsync and vsync on the same clk edge, giving one cycle of latency from pix_x/pix_y to the pads with the colour and sync outputs mutually aligned.
REQ-015 SHALL force R/G/B to 0 throughout all blanking intervals, whatever R_in/G_in/B_in are driven to.
REQ-016 SHALL produce a single hsync pulse of exactly H_SYNC enabled clocks per line and a vsync pulse of exactly V_SYNC lines per frame, with no glitches.

Reset
REQ-017 SHALL, while rst_n=0, asynchronously force h_cnt=0, v_cnt=0, counter=0, hsync=1, vsync=1 and R=G=B=0.
REQ-018 SHALL therefore show pix_x=0, pix_y=0, video_active=1 and frame_start=1 during reset.
REQ-019 SHALL begin counting on the first enabled clk edge after rst_n deasserts; an assertion mid-frame SHALL abort the frame with no partial sync pulse remaining.

Verification
REQ-020 Reset release, clk_en=1, 800 clocks -> pix_x steps 0..799 then returns to 0; pix_y goes 0 to 1 on that wrap.
REQ-021 Continuous run of one full frame -> hsync low for exactly 96 clocks starting the cycle after h_cnt=656; vsync low for exactly 2x800 clocks starting the cycle after v_cnt=490 with h_cnt=0; counter goes 0 to 1 when frame_start rises, after 420000 clocks.
REQ-022 R_in=G_in=B_in=2'b11 held constant -> R/G/B=3 for exactly 640 clocks per visible line, 0 otherwise, and 0 for all of lines 480..524.
REQ-023 clk_en toggled 1,0,1,0... -> the frame takes 840000 clocks and outputs are unchanged across clk_en=0 cycles.
REQ-024 rst_n pulsed low at h_cnt=700, v_cnt=300 -> immediately hsync=1, R/G/B=0, pix_x=0, pix_y=0; counter does not advance and the next frame starts cleanly.
REQ-025 1024 frames run -> counter wraps from 1023 to 0 together with frame_start.
